uart_apb_poller: RTL and testbench

APB master that sits directly upstream of a CoreUARTapb instance and replaces a CPU in driving it. After reset it programs the UART's baud and control registers. It then polls the status register continuously, drains received bytes into a valid/ready output stream and feeds bytes from a valid/ready input stream into the transmitter. This lets DMInterface logic exchange raw bytes with the UART without software.

---
 rtl/uart_apb_poller_pkg.sv | 29 ++
 rtl/apb_xfer_engine.sv | 53 +++++
 rtl/uart_apb_poller.sv | 155 +++++++++++++++
 tb/tb_uart_apb_poller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_poller_pkg.sv
// Register map, STATUS bit positions and poller FSM states.
// Shared by uart_apb_poller and apb_xfer_engine.
package uart_apb_poller_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam int ST_TXRDY    = 0;
  localparam int ST_RXRDY    = 1;
  localparam int ST_PARITY   = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_FRAMING  = 4;

  typedef enum logic [2:0] {
    CFG1,
    CFG2,
    POLL,
    RD_RX,
    WR_TX
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apb_xfer_engine.sv
// Single-transfer APB sequencer: setup, access until PREADY.
// A new setup may be launched in the completing cycle.
module apb_xfer_engine
  import uart_apb_poller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  output logic [4:0] paddr,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  logic free;

  assign done  = psel & penable & pready;
  assign rdata = prdata;
  assign err   = done & pslverr;
  assign free  = ~psel | done;

  always_ff @(posedge clk) begin
    if (rst) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (start && free) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= write;
      paddr   <= addr;
      pwdata  <= wdata;
    end else if (done) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else if (psel) begin
      penable <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_apb_poller.sv
// APB master that programs and polls a CoreUARTapb, bridging bytes to streams.
// UART_POLL_ERRCNT_EN adds saturating parity/framing/overflow counters.
module uart_apb_poller
  import uart_apb_poller_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic        PRG_BIT8   = 1'b1,
  parameter logic [1:0]  PRG_PARITY = 2'b00
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       CFG_DONE,
  output logic       APB_ERR
`ifdef UART_POLL_ERRCNT_EN
  ,
  output logic [7:0] PARITY_CNT,
  output logic [7:0] FRAMING_CNT,
  output logic [7:0] OVERFLOW_CNT
`endif
);

  state_t     state;
  state_t     nxt;
  logic       done;
  logic       err;
  logic [7:0] rdata;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       write;
  logic       rx_go;
  logic       tx_go;
  logic       unused_rdata;

  // A full output register leaves RXRDY pending in the UART FIFO.
  assign rx_go = rdata[ST_RXRDY] & ~RX_VALID;
  assign tx_go = rdata[ST_TXRDY] & TX_VALID;

  always_comb begin
    nxt = state;
    if (done) begin
      unique case (state)
        CFG1:    nxt = CFG2;
        CFG2:    nxt = POLL;
        POLL:    nxt = rx_go ? RD_RX : (tx_go ? WR_TX : POLL);
        default: nxt = POLL;
      endcase
    end
  end

  // Request follows the next state so setup starts with no idle gap.
  always_comb begin
    addr  = ADDR_STATUS;
    wdata = '0;
    write = 1'b0;
    unique case (nxt)
      CFG1: begin
        addr  = ADDR_CTRL1;
        wdata = BAUD_VALUE[7:0];
        write = 1'b1;
      end
      CFG2: begin
        addr  = ADDR_CTRL2;
        wdata = {BAUD_VALUE[12:8], PRG_PARITY, PRG_BIT8};
        write = 1'b1;
      end
      RD_RX: addr = ADDR_RXDATA;
      WR_TX: begin
        addr  = ADDR_TXDATA;
        wdata = TX_DATA;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  apb_xfer_engine u_eng (
    .clk     (PCLK),
    .rst     (PRESET),
    .start   (1'b1),
    .addr    (addr),
    .wdata   (wdata),
    .write   (write),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .paddr   (PADDR),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .pwdata  (PWDATA),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= CFG1;
      CFG_DONE <= 1'b0;
      APB_ERR  <= 1'b0;
      TX_READY <= 1'b0;
      RX_VALID <= 1'b0;
      RX_DATA  <= '0;
    end else begin
      state    <= nxt;
      TX_READY <= done && (state == WR_TX);
      if (err)
        APB_ERR <= 1'b1;
      if (done && (state == CFG2))
        CFG_DONE <= 1'b1;
      if (done && (state == RD_RX)) begin
        RX_DATA  <= rdata;
        RX_VALID <= 1'b1;
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

`ifdef UART_POLL_ERRCNT_EN
  assign unused_rdata = ^rdata[7:5];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PARITY_CNT   <= '0;
      FRAMING_CNT  <= '0;
      OVERFLOW_CNT <= '0;
    end else if (done && (state == POLL)) begin
      if (rdata[ST_PARITY])
        PARITY_CNT <= sat_inc(PARITY_CNT);
      if (rdata[ST_FRAMING])
        FRAMING_CNT <= sat_inc(FRAMING_CNT);
      if (rdata[ST_OVERFLOW])
        OVERFLOW_CNT <= sat_inc(OVERFLOW_CNT);
    end
  end
`else
  assign unused_rdata = ^rdata[7:2];
`endif

endmodule

// File: tb/tb_uart_apb_poller.sv
// Bench for uart_apb_poller: behavioural UART slave with loopback,
// transaction-level expectation model and directed scenarios.
module tb_uart_apb_poller;

  localparam logic [12:0] BAUD = 13'h0145;
  localparam logic        BIT8 = 1'b1;
  localparam logic [1:0]  PAR  = 2'b01;
  localparam logic [7:0]  CTRL2_VAL = {BAUD[12:8], PAR, BIT8};

  localparam logic [4:0] A_TX = 5'h00;
  localparam logic [4:0] A_RX = 5'h04;
  localparam logic [4:0] A_C1 = 5'h08;
  localparam logic [4:0] A_C2 = 5'h0C;
  localparam logic [4:0] A_ST = 5'h10;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [4:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;
  logic [7:0] TX_DATA;
  logic       TX_VALID, TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID, RX_READY;
  logic       CFG_DONE, APB_ERR;
`ifdef UART_POLL_ERRCNT_EN
  logic [7:0] PARITY_CNT, FRAMING_CNT, OVERFLOW_CNT;
`endif

  uart_apb_poller #(
    .BAUD_VALUE (BAUD),
    .PRG_BIT8   (BIT8),
    .PRG_PARITY (PAR)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .CFG_DONE (CFG_DONE),
`ifdef UART_POLL_ERRCNT_EN
    .PARITY_CNT   (PARITY_CNT),
    .FRAMING_CNT  (FRAMING_CNT),
    .OVERFLOW_CNT (OVERFLOW_CNT),
`endif
    .APB_ERR  (APB_ERR)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // slave knobs
  logic       txrdy = 1'b1;
  int         st_waits = 0;
  logic       err_on_tx = 1'b0;
  logic [7:0] err_bits = '0;
  logic [7:0] fifo[$];
  logic [7:0] sent[$];
  logic [7:0] rcv[$];

  // expectation model
  logic       was_rst = 1'b1;
  logic       exp_setup = 1'b0;
  logic [4:0] ex_addr = A_C1;
  logic       ex_wr = 1'b1;
  logic [7:0] ex_wd = BAUD[7:0];
  logic       m_done = 1'b0, m_err = 1'b0;
  logic       m_rxv = 1'b0, m_txr = 1'b0;
  logic [7:0] m_rxd = '0;
  logic [4:0] cur_addr = '0;
  int         acc_cnt = 0, wl = 0, cur_w = 0;
  int         max_pen = 0, rd_cnt = 0, cfg_cnt = 0;
  logic [7:0] cfg1_val = '0, cfg2_val = '0;

  always @(negedge PCLK) begin : mon
    logic       rst_now, fin, hs;
    logic [7:0] st, b;
    rst_now = PRESET;
    fin = 1'b0;
    chk("cfg_done", 32'(CFG_DONE), 32'(m_done));
    chk("apb_err", 32'(APB_ERR), 32'(m_err));
    chk("rx_valid", 32'(RX_VALID), 32'(m_rxv));
    chk("tx_ready", 32'(TX_READY), 32'(m_txr));
    if (m_rxv)
      chk("rx_data", 32'(RX_DATA), 32'(m_rxd));
    if (was_rst) begin
      chk("rst_ctl", 32'({PSEL, PENABLE, PWRITE}), 32'(0));
      chk("rst_paddr", 32'(PADDR), 32'(0));
      chk("rst_pwdata", 32'(PWDATA), 32'(0));
      chk("rst_rxdata", 32'(RX_DATA), 32'(0));
`ifdef UART_POLL_ERRCNT_EN
      chk("rst_cnt", 32'({PARITY_CNT, FRAMING_CNT, OVERFLOW_CNT}), 32'(0));
`endif
    end else if (exp_setup) begin
      chk("no_gap", 32'({PSEL, PENABLE}), 32'(2'b10));
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    PRDATA = '0;
    if (!was_rst && PSEL) begin
      if (!PENABLE) begin
        chk("setup_addr", 32'(PADDR), 32'(ex_addr));
        chk("setup_wr", 32'(PWRITE), 32'(ex_wr));
        if (ex_wr)
          chk("setup_wdata", 32'(PWDATA), 32'(ex_wd));
        cur_addr = PADDR;
        acc_cnt = 0;
        wl = (PADDR == A_ST) ? st_waits : 0;
        cur_w = wl;
      end else begin
        acc_cnt++;
        chk("addr_hold", 32'(PADDR), 32'(cur_addr));
        if (wl > 0) wl--;
        else begin
          PREADY = 1'b1;
          fin = 1'b1;
        end
      end
    end
    hs = m_rxv && RX_READY && !rst_now;
    m_txr = 1'b0;
    if (fin && !rst_now) begin
      chk("pen_len", 32'(acc_cnt), 32'(cur_w + 1));
      if (acc_cnt > max_pen) max_pen = acc_cnt;
      ex_addr = A_ST;
      ex_wr = 1'b0;
      ex_wd = '0;
      if (cur_addr == A_ST) begin
        st = err_bits;
        st[0] = txrdy;
        st[1] = (fifo.size() != 0);
        PRDATA = st;
        if (st[1] && !m_rxv) begin
          ex_addr = A_RX;
        end else if (st[0] && TX_VALID) begin
          ex_addr = A_TX;
          ex_wr = 1'b1;
          ex_wd = TX_DATA;
        end
      end else if (cur_addr == A_RX) begin
        b = (fifo.size() != 0) ? fifo.pop_front() : 8'h00;
        PRDATA = b;
        m_rxv = 1'b1;
        m_rxd = b;
        rd_cnt++;
      end else if (cur_addr == A_TX) begin
        if (err_on_tx) begin
          PSLVERR = 1'b1;
          err_on_tx = 1'b0;
        end
        fifo.push_back(PWDATA);
        m_txr = 1'b1;
      end else if (cur_addr == A_C1) begin
        cfg1_val = PWDATA;
        cfg_cnt++;
        ex_addr = A_C2;
        ex_wr = 1'b1;
        ex_wd = CTRL2_VAL;
      end else begin
        cfg2_val = PWDATA;
        cfg_cnt++;
        m_done = 1'b1;
      end
      if (PSLVERR) m_err = 1'b1;
    end
    if (hs) begin
      b = (sent.size() != 0) ? sent.pop_front() : 8'hXX;
      chk("rx_order", 32'(RX_DATA), 32'(b));
      rcv.push_back(RX_DATA);
      m_rxv = 1'b0;
    end
    if (rst_now) begin
      m_done = 1'b0;
      m_err = 1'b0;
      m_rxv = 1'b0;
      m_rxd = '0;
      m_txr = 1'b0;
      ex_addr = A_C1;
      ex_wr = 1'b1;
      ex_wd = BAUD[7:0];
      wl = 0;
    end
    exp_setup = !rst_now && (was_rst || fin);
    was_rst = rst_now;
  end

  task automatic send(input logic [7:0] v);
    int t;
    @(posedge PCLK); #1;
    TX_DATA = v;
    TX_VALID = 1'b1;
    sent.push_back(v);
    t = 0;
    do begin
      @(negedge PCLK);
      t++;
    end while (!TX_READY && t < 300);
    chk("tx_accept", 32'(TX_READY), 32'(1));
    @(posedge PCLK); #1;
    TX_VALID = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rcv.size() < n && t < 400) begin
      @(negedge PCLK);
      t++;
    end
    chk("rx_count", 32'(rcv.size()), 32'(n));
  endtask

  initial begin
    int t, rd0, cfg0;
    PRESET = 1'b1;
    TX_VALID = 1'b0;
    TX_DATA = '0;
    RX_READY = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    repeat (4) @(posedge PCLK);
    @(negedge PCLK);
    chk("cfg_done_c4", 32'(CFG_DONE), 32'(0));
    @(posedge PCLK);
    @(negedge PCLK);
    chk("cfg_done_c5", 32'(CFG_DONE), 32'(1));
    chk("ctrl1_val", 32'(cfg1_val), 32'(8'h45));
    chk("ctrl2_val", 32'(cfg2_val), 32'(8'h0B));

    send(8'hA5);
    send(8'h3C);
    wait_rx(2);
    chk("rx0", 32'(rcv[0]), 32'(8'hA5));
    chk("rx1", 32'(rcv[1]), 32'(8'h3C));

    @(posedge PCLK); #1;
    RX_READY = 1'b0;
    rd0 = rd_cnt;
    fifo.push_back(8'h11); sent.push_back(8'h11);
    fifo.push_back(8'h22); sent.push_back(8'h22);
    fifo.push_back(8'h33); sent.push_back(8'h33);
    repeat (40) @(posedge PCLK);
    @(negedge PCLK);
    chk("bp_valid", 32'(RX_VALID), 32'(1));
    chk("bp_data", 32'(RX_DATA), 32'(8'h11));
    chk("bp_reads", 32'(rd_cnt - rd0), 32'(1));
    @(posedge PCLK); #1;
    RX_READY = 1'b1;
    wait_rx(5);
    chk("rx3", 32'(rcv[3]), 32'(8'h22));
    chk("rx4", 32'(rcv[4]), 32'(8'h33));

    @(posedge PCLK); #1;
    st_waits = 3;
    send(8'h77);
    wait_rx(6);
    chk("wait_pen", 32'(max_pen), 32'(4));
    st_waits = 0;

    @(posedge PCLK); #1;
    err_on_tx = 1'b1;
    send(8'h5A);
    wait_rx(7);
    chk("err_sticky", 32'(APB_ERR), 32'(1));
    chk("rx6", 32'(rcv[6]), 32'(8'h5A));

    @(posedge PCLK); #1;
    st_waits = 3;
    t = 0;
    do begin
      @(negedge PCLK);
      t++;
    end while (!(PSEL && PENABLE) && t < 50);
    chk("mid_access", 32'(PENABLE), 32'(1));
    cfg0 = cfg_cnt;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_abort", 32'({PSEL, PENABLE}), 32'(0));
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    st_waits = 0;
    t = 0;
    while (!CFG_DONE && t < 100) begin
      @(negedge PCLK);
      t++;
    end
    chk("cfg_redo", 32'(CFG_DONE), 32'(1));
    chk("err_cleared", 32'(APB_ERR), 32'(0));
    chk("cfg_rewrites", 32'(cfg_cnt - cfg0), 32'(2));

`ifdef UART_POLL_ERRCNT_EN
    @(posedge PCLK); #1;
    err_bits = 8'h14;
    repeat (700) @(posedge PCLK);
    @(negedge PCLK);
    chk("parity_cnt", 32'(PARITY_CNT), 32'(8'hFF));
    chk("framing_cnt", 32'(FRAMING_CNT), 32'(8'hFF));
    chk("overflow_cnt", 32'(OVERFLOW_CNT), 32'(0));
    @(posedge PCLK); #1;
    err_bits = '0;
`endif

    repeat (5) @(posedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
